// File: rtl/mdu_divider.sv
// -----------------------------------------------------------------------------
// mdu_divider
//   Iterative radix-2 restoring divider for the execute-stage MDU. Implements
//   RISC-V DIV / DIVU / REM / REMU, one quotient bit per cycle, and carries an
//   opaque tag through to writeback. Divide-by-zero and signed overflow are
//   resolved at acceptance without iterating.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous, active-low reset
//   flush       abort any in-flight operation (wins over every handshake)
//   in_valid    request valid
//   in_ready    divider idle and not being flushed
//   in_op       00 DIV, 01 DIVU, 10 REM, 11 REMU
//   in_a/in_b   dividend / divisor
//   in_tag      pass-through tag
//   out_valid   result valid (held until out_ready)
//   out_ready   consumer accepts result
//   out_result  quotient or remainder
//   out_tag     tag of the request that produced out_result
// -----------------------------------------------------------------------------
module mdu_divider #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              op_rem;
  logic              neg_q;
  logic              neg_r;
  logic [XLEN-1:0]   divisor;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   quo;

  // Acceptance-time decode of the incoming request.
  logic              in_signed;
  logic              in_rem;
  logic [XLEN-1:0]   a_abs;
  logic [XLEN-1:0]   b_abs;
  logic              div_zero;
  logic              overflow;

  assign in_ready  = (state == IDLE) && !flush;
  assign in_signed = ~in_op[0];
  assign in_rem    = in_op[1];
  assign a_abs     = (in_signed && in_a[XLEN-1]) ? -in_a : in_a;
  assign b_abs     = (in_signed && in_b[XLEN-1]) ? -in_b : in_b;
  assign div_zero  = (in_b == '0);
  assign overflow  = in_signed && (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (&in_b);

  // One restoring step. rem < divisor always holds, so a non-negative
  // difference fits in XLEN bits and bit XLEN of the result is a pure borrow.
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     diff;
  logic [XLEN-1:0]   rem_next;
  logic [XLEN-1:0]   quo_next;
  logic [XLEN-1:0]   result_fixed;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    shifted  = {rem, quo[XLEN-1]};
    diff     = shifted - {1'b0, divisor};
    rem_next = shifted[XLEN-1:0];
    quo_next = {quo[XLEN-2:0], 1'b0};
    if (!diff[XLEN]) begin
      rem_next = diff[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end
  end

  // The remainder follows the dividend's sign; the quotient is negative when
  // the operand signs differ.
  assign result_fixed = op_rem ? (neg_r ? -rem : rem)
                               : (neg_q ? -quo : quo);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the datapath registers are reset as well; they are few, and it keeps
  // every output deterministic straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_rem     <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      divisor    <= '0;
      rem        <= '0;
      quo        <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            out_tag <= in_tag;
            op_rem  <= in_rem;
            if (div_zero) begin
              out_result <= in_rem ? in_a : '1;
              state      <= DONE;
            end else if (overflow) begin
              out_result <= in_rem ? '0 : in_a;
              state      <= DONE;
            end else begin
              neg_q   <= in_signed && (in_a[XLEN-1] ^ in_b[XLEN-1]);
              neg_r   <= in_signed && in_a[XLEN-1];
              divisor <= b_abs;
              rem     <= '0;
              quo     <= a_abs;
              cnt     <= '0;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(XLEN - 1)) state <= SIGN;
        end
        SIGN: begin
          out_result <= result_fixed;
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          // Special cases arrive here straight from IDLE with out_valid still
          // low; it rises on the first DONE cycle.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_divider.sv
// -----------------------------------------------------------------------------
// tb_mdu_divider
//   Directed self-checking bench for mdu_divider (XLEN=32, TAG_W=6): hand
//   computed vectors, special cases, latency, backpressure, flush, reset and an
//   operand sweep checked against a reference model.
// -----------------------------------------------------------------------------
module tb_mdu_divider;

  localparam int XLEN  = 32;
  localparam int TAG_W = 6;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = '0;
  logic [XLEN-1:0]  in_a = '0;
  logic [XLEN-1:0]  in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  int errors = 0;
  int checks = 0;

  mdu_divider #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model of the RISC-V division semantics.
  function automatic logic [XLEN-1:0] model(input logic [1:0] op,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    if (b == 0) return op[1] ? a : '1;
    if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? '0 : a;
      q = sa / sb;
      r = sa % sb;
      return op[1] ? XLEN'(r) : XLEN'(q);
    end
    ua = longint'(a);
    ub = longint'(b);
    return op[1] ? XLEN'(ua % ub) : XLEN'(ua / ub);
  endfunction

  // Present one request; returns #1 after its accept edge.
  task automatic start(input logic [1:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_tag   = '0;
  endtask

  // Cycles from the accept edge until out_valid is seen, bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("valid_within_bound", out_valid, 1'b1);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                       output logic [XLEN-1:0] res, output logic [TAG_W-1:0] rtag,
                       output int lat);
    out_ready = 1'b1;
    start(op, a, b, tag);
    wait_valid(lat);
    res  = out_result;
    rtag = out_tag;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string           name;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
    int              lat;
  } vec_t;

  vec_t vecs[10] = '{
    '{"divu_100_7",  OP_DIVU, 32'd100,        32'd7,          32'd14,         33},
    '{"remu_100_7",  OP_REMU, 32'd100,        32'd7,          32'd2,          33},
    '{"div_m7_2",    OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33},
    '{"rem_m7_2",    OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33},
    '{"div_7_m2",    OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33},
    '{"rem_7_m2",    OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33},
    '{"divu_5_0",    OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1},
    '{"rem_5_0",     OP_REM,  32'd5,          32'd0,          32'd5,          1},
    '{"div_ovf",     OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1},
    '{"rem_ovf",     OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1}
  };

  logic [XLEN-1:0] sweep_vals[8];

  initial begin
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] rtag;
    logic [XLEN-1:0]  r0;
    logic [TAG_W-1:0] t0;
    int               lat;
    bit               ok;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid",  out_valid,  1'b0);
    check("rst_out_result", out_result, '0);
    check("rst_out_tag",    out_tag,    '0);
    check("rst_in_ready",   in_ready,   1'b1);
    @(negedge clk);
    rst = 1'b1;

    // Directed vectors.
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, TAG_W'(i + 3), res, rtag, lat);
      check({vecs[i].name, "_result"}, res, vecs[i].exp);
      check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
      check({vecs[i].name, "_tag"}, rtag, TAG_W'(i + 3));
      check({vecs[i].name, "_in_ready_after"}, in_ready, 1'b1);
    end

    // Backpressure: result and tag frozen while out_ready stays low.
    out_ready = 1'b0;
    start(OP_DIVU, 32'd1000, 32'd10, 6'h2a);
    wait_valid(lat);
    r0 = out_result;
    t0 = out_tag;
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_result !== r0 || out_tag !== t0 || out_valid !== 1'b1 || in_ready !== 1'b0)
        ok = 1'b0;
    end
    check("bp_stable", ok, 1'b1);
    check("bp_result", out_result, 32'd100);
    check("bp_tag", out_tag, 6'h2a);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_valid_dropped", out_valid, 1'b0);
    check("bp_idle_ready", in_ready, 1'b1);
    start(OP_DIVU, 32'd50, 32'd5, 6'h15);
    check("bp_second_accepted", in_ready, 1'b0);
    wait_valid(lat);
    check("bp_second_result", out_result, 32'd10);
    check("bp_second_tag", out_tag, 6'h15);
    @(posedge clk);
    #1;

    // Flush during CALC iteration 10.
    start(OP_DIVU, 32'd1000, 32'd3, 6'h07);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_in_ready_low", in_ready, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    #1;
    check("flush_idle_ready", in_ready, 1'b1);
    ok = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    check("flush_no_valid", ok, 1'b1);
    do_op(OP_DIVU, 32'd9, 32'd3, 6'h09, res, rtag, lat);
    check("post_flush_result", res, 32'd3);
    check("post_flush_latency", lat, 33);

    // Flush with in_valid in IDLE: no accept.
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_op    = OP_DIVU;
    in_a     = 32'd20;
    in_b     = 32'd0;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_idle_no_accept", in_ready, 1'b1);
    ok = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    check("flush_idle_no_valid", ok, 1'b1);

    // Asynchronous reset in the middle of CALC.
    start(OP_DIV, 32'd12345, 32'd17, 6'h11);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_idle", in_ready, 1'b1);
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_tag", out_tag, '0);
    @(negedge clk);
    rst = 1'b1;

    // Operand sweep against the reference model.
    sweep_vals = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd7,
                   32'hFFFF_FFF9, $urandom(), $urandom()};
    foreach (sweep_vals[i]) begin
      foreach (sweep_vals[j]) begin
        for (int op = 0; op < 4; op++) begin
          do_op(2'(op), sweep_vals[i], sweep_vals[j], TAG_W'(i * 8 + j), res, rtag, lat);
          check($sformatf("sweep_op%0d_%0h_%0h", op, sweep_vals[i], sweep_vals[j]),
                res, model(2'(op), sweep_vals[i], sweep_vals[j]));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
